// File: rtl/apb_bridge_arbiter.sv
// Round-robin arbiter sharing one AHB-to-APB bridge transaction path between
// NUM_REQ requesters, with hr_readyout low/high completion tracking and a watchdog.
module apb_bridge_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_grant,
  output logic [NUM_REQ-1:0]      req_done,
  output logic                    req_err,
  output logic [31:0]             req_rdata,
  output logic                    valid,
  output logic                    hwrite,
  output logic [31:0]             haddr,
  output logic [31:0]             hwdata,
  input  logic                    hr_readyout,
  input  logic [31:0]             prdata
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_err;
  logic [31:0]          r_rdata;
  logic                 r_valid;
  logic                 r_hwrite;
  logic [31:0]          r_haddr;
  logic [31:0]          r_hwdata;

  state_t               w_state_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [IDX_W-1:0]     w_rr_ptr_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [NUM_REQ-1:0]   w_grant_nxt;
  logic [NUM_REQ-1:0]   w_done_nxt;
  logic                 w_err_nxt;
  logic [31:0]          w_rdata_nxt;
  logic                 w_valid_nxt;
  logic                 w_hwrite_nxt;
  logic [31:0]          w_haddr_nxt;
  logic [31:0]          w_hwdata_nxt;

  logic                 w_any_req;
  logic                 w_hit_hi;
  logic [IDX_W-1:0]     w_win;
  logic                 w_sel_write;
  logic [31:0]          w_sel_addr;
  logic [31:0]          w_sel_wdata;
  logic                 w_limit;

  // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall.
  always_comb begin
    w_any_req   = |req_valid;
    w_hit_hi    = 1'b0;
    w_win       = '0;
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(r_rr_ptr))) begin
        w_hit_hi    = 1'b1;
        w_win       = IDX_W'(i);
        w_sel_write = req_write[i];
        w_sel_addr  = req_addr[i*32 +: 32];
        w_sel_wdata = req_wdata[i*32 +: 32];
      end
    end
    if (!w_hit_hi) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          w_win       = IDX_W'(i);
          w_sel_write = req_write[i];
          w_sel_addr  = req_addr[i*32 +: 32];
          w_sel_wdata = req_wdata[i*32 +: 32];
        end
      end
    end
  end

  // A counter past the limit can only be seen in WAIT_HIGH after a last-cycle WAIT_LOW exit.
  assign w_limit = (r_cnt >= CNT_LIMIT);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_rr_ptr_nxt = r_rr_ptr;
    w_cnt_nxt    = r_cnt;
    w_grant_nxt  = r_grant;
    w_done_nxt   = '0;
    w_err_nxt    = r_err;
    w_rdata_nxt  = r_rdata;
    w_valid_nxt  = 1'b0;
    w_hwrite_nxt = r_hwrite;
    w_haddr_nxt  = r_haddr;
    w_hwdata_nxt = r_hwdata;

    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt  = ISSUE;
          w_idx_nxt    = w_win;
          w_grant_nxt  = NUM_REQ'(1) << w_win;
          w_hwrite_nxt = w_sel_write;
          w_haddr_nxt  = w_sel_addr;
          w_hwdata_nxt = w_sel_wdata;
          w_valid_nxt  = 1'b1;
        end
      end
      ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (!hr_readyout) begin
          w_state_nxt = WAIT_HIGH;
        end else if (w_limit) begin
          w_state_nxt = DONE;
          w_done_nxt  = r_grant;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = '0;
        end
      end
      WAIT_HIGH: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (hr_readyout) begin
          w_state_nxt = DONE;
          w_done_nxt  = r_grant;
          w_err_nxt   = 1'b0;
          w_rdata_nxt = r_hwrite ? 32'd0 : prdata;
        end else if (w_limit) begin
          w_state_nxt = DONE;
          w_done_nxt  = r_grant;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = '0;
        end
      end
      DONE: begin
        w_state_nxt  = IDLE;
        w_grant_nxt  = '0;
        w_rr_ptr_nxt = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction without a done pulse.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_valid  <= 1'b0;
      r_hwrite <= 1'b0;
      r_haddr  <= '0;
      r_hwdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_rdata  <= w_rdata_nxt;
      r_valid  <= w_valid_nxt;
      r_hwrite <= w_hwrite_nxt;
      r_haddr  <= w_haddr_nxt;
      r_hwdata <= w_hwdata_nxt;
    end
  end

  assign req_grant = r_grant;
  assign req_done  = r_done;
  assign req_err   = r_err;
  assign req_rdata = r_rdata;
  assign valid     = r_valid;
  assign hwrite    = r_hwrite;
  assign haddr     = r_haddr;
  assign hwdata    = r_hwdata;

endmodule
